// File: rtl/switch_pkg.sv
// Shared switch-core types: port sizing, MAC/mask types, learn-table entry and FSM states.
// With MAC_TABLE_AGING_EN defined, each table entry also carries an age bit.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int MAC_W     = 48;

    typedef logic [MAC_W-1:0]     mac_t;
    typedef logic [NUM_PORTS-1:0] port_mask_t;
    typedef logic [PORT_W-1:0]    port_t;

    typedef struct packed {
        logic  valid;
        mac_t  mac;
        port_t port;
`ifdef MAC_TABLE_AGING_EN
        logic  age;
`endif
    } mac_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_RESP  = 2'd2
    } lt_state_t;

    // Every port except the one the frame arrived on.
    function automatic port_mask_t flood_mask(port_t p);
        port_mask_t m;
        m    = '1;
        m[p] = 1'b0;
        return m;
    endfunction

    function automatic port_mask_t onehot_mask(port_t p);
        port_mask_t m;
        m    = '0;
        m[p] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mac_table_cam.sv
// Combinational fully associative match of one MAC key against all valid entries.
// Reports a hit and the lowest matching index.
module mac_table_cam
    import switch_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0]       i_valid,
    input  logic [NUM_ENTRIES*MAC_W-1:0] i_macs,
    input  logic [MAC_W-1:0]             i_key,
    output logic                         o_hit,
    output logic [IDX_W-1:0]             o_idx
);

    logic [NUM_ENTRIES-1:0] w_match;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = i_valid[i] && (i_macs[i*MAC_W +: MAC_W] == i_key);
        end
    end

    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mac_learn_table.sv
// Source-MAC learning / destination lookup table: IDLE -> MATCH -> RESP per request.
// Optional aging sweep compiled in with MAC_TABLE_AGING_EN.
module mac_learn_table
    import switch_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int AGE_TICKS   = 1000000
) (
    input  logic                         switch_clk,
    input  logic                         switch_rst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [47:0]                  req_dst_mac_i,
    input  logic [47:0]                  req_src_mac_i,
    input  logic [PORT_W-1:0]            req_port_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [NUM_PORTS-1:0]         resp_port_mask_o,
    output logic                         resp_hit_o,
    input  logic                         flush_i,
    output logic [$clog2(NUM_ENTRIES):0] occupancy_o,
    output logic [1:0]                   dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    // Request side is valid/ready: a request transfers on a cycle where both are high;
    // the response holds valid and data stable until resp_ready_i is seen high.
    mac_entry_t       r_table [NUM_ENTRIES];
    lt_state_t        r_state;
    mac_t             r_dst_mac;
    mac_t             r_src_mac;
    port_t            r_in_port;
    logic             r_src_hit;
    logic [IDX_W-1:0] r_src_idx;
    logic             r_free_any;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_repl_ptr;
    logic             r_learn_pending;
    logic             r_resp_valid;
    port_mask_t       r_resp_mask;
    logic             r_resp_hit;

    logic [NUM_ENTRIES-1:0]       w_valid_vec;
    logic [NUM_ENTRIES*MAC_W-1:0] w_mac_vec;
    logic                         w_dst_hit;
    logic [IDX_W-1:0]             w_dst_idx;
    logic                         w_src_hit;
    logic [IDX_W-1:0]             w_src_idx;
    logic                         w_free_any;
    logic [IDX_W-1:0]             w_free_idx;
    port_mask_t                   w_resp_mask;
    logic                         w_resp_hit;
    logic                         w_learn_ok;
    logic [IDX_W-1:0]             w_learn_idx;
    logic [OCC_W-1:0]             w_occ;
    logic                         w_age_pulse;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_valid_vec[i]                 = r_table[i].valid;
            w_mac_vec[i*MAC_W +: MAC_W]    = r_table[i].mac;
        end
    end

    mac_table_cam #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_dst_cam (
        .i_valid (w_valid_vec),
        .i_macs  (w_mac_vec),
        .i_key   (r_dst_mac),
        .o_hit   (w_dst_hit),
        .o_idx   (w_dst_idx)
    );

    mac_table_cam #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_src_cam (
        .i_valid (w_valid_vec),
        .i_macs  (w_mac_vec),
        .i_key   (r_src_mac),
        .o_hit   (w_src_hit),
        .o_idx   (w_src_idx)
    );

    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_table[i].valid) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Group bit (bit 40) on dst always floods; a unicast hit back to the ingress port is filtered.
    always_comb begin
        w_resp_hit  = 1'b0;
        w_resp_mask = flood_mask(r_in_port);
        if (!r_dst_mac[40] && w_dst_hit) begin
            w_resp_hit = 1'b1;
            if (r_table[w_dst_idx].port == r_in_port) begin
                w_resp_mask = '0;
            end else begin
                w_resp_mask = onehot_mask(r_table[w_dst_idx].port);
            end
        end
    end

    assign w_learn_ok  = !r_src_mac[40] && (r_src_mac != '0);
    assign w_learn_idx = r_src_hit  ? r_src_idx  :
                         r_free_any ? r_free_idx : r_repl_ptr;

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_occ = w_occ + OCC_W'(r_table[i].valid);
        end
    end

`ifdef MAC_TABLE_AGING_EN
    logic [31:0] r_age_cnt;

    assign w_age_pulse = (r_age_cnt == 32'(AGE_TICKS - 1));

    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            r_age_cnt <= '0;
        end else if (w_age_pulse) begin
            r_age_cnt <= '0;
        end else begin
            r_age_cnt <= r_age_cnt + 32'd1;
        end
    end
`else
    assign w_age_pulse = 1'b0;
`endif

    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            r_state         <= ST_IDLE;
            r_dst_mac       <= '0;
            r_src_mac       <= '0;
            r_in_port       <= '0;
            r_src_hit       <= 1'b0;
            r_src_idx       <= '0;
            r_free_any      <= 1'b0;
            r_free_idx      <= '0;
            r_learn_pending <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_mask     <= '0;
            r_resp_hit      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_dst_mac <= req_dst_mac_i;
                        r_src_mac <= req_src_mac_i;
                        r_in_port <= req_port_i;
                        r_state   <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    r_src_hit       <= w_src_hit;
                    r_src_idx       <= w_src_idx;
                    r_free_any      <= w_free_any;
                    r_free_idx      <= w_free_idx;
                    r_resp_mask     <= w_resp_mask;
                    r_resp_hit      <= w_resp_hit;
                    r_resp_valid    <= 1'b1;
                    r_learn_pending <= w_learn_ok;
                    r_state         <= ST_RESP;
                end
                ST_RESP: begin
                    r_learn_pending <= 1'b0;
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_resp_mask  <= '0;
                        r_resp_hit   <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write order matters: aging first, then the learn (so it wins), then flush (so it wins over both).
    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_table[i] <= '0;
            end
            r_repl_ptr <= '0;
        end else begin
`ifdef MAC_TABLE_AGING_EN
            if (w_age_pulse) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (r_table[i].valid) begin
                        if (r_table[i].age) begin
                            r_table[i].valid <= 1'b0;
                        end else begin
                            r_table[i].age <= 1'b1;
                        end
                    end
                end
            end
`endif
            if (r_learn_pending) begin
                r_table[w_learn_idx].valid <= 1'b1;
                r_table[w_learn_idx].mac   <= r_src_mac;
                r_table[w_learn_idx].port  <= r_in_port;
`ifdef MAC_TABLE_AGING_EN
                r_table[w_learn_idx].age   <= 1'b0;
`endif
                if (!r_src_hit && !r_free_any) begin
                    r_repl_ptr <= r_repl_ptr + IDX_W'(1);
                end
            end
            if (flush_i) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    r_table[i].valid <= 1'b0;
                end
            end
        end
    end

    assign req_ready_o      = (r_state == ST_IDLE) && !switch_rst;
    assign resp_valid_o     = r_resp_valid;
    assign resp_port_mask_o = r_resp_mask;
    assign resp_hit_o       = r_resp_hit;
    assign occupancy_o      = w_occ;
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_mac_learn_table.sv
// Directed + randomized bench for mac_learn_table against a lazy table/aging model.
// The aging scenario is compiled in with MAC_TABLE_AGING_EN.
module tb_mac_learn_table;
    import switch_pkg::*;

    localparam int NE = 16;
    localparam int AT = 100;
`ifdef MAC_TABLE_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [47:0]      req_dst;
    logic [47:0]      req_src;
    logic [PORT_W-1:0] req_port;
    logic             resp_valid;
    logic             resp_ready;
    logic [NUM_PORTS-1:0] resp_mask;
    logic             resp_hit;
    logic             flush;
    logic [$clog2(NE):0] occ;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    int edge_cnt;

    bit    m_valid [NE];
    mac_t  m_mac   [NE];
    port_t m_port  [NE];
    int    m_learn [NE];
    int    m_ptr;
    mac_t  learned [$];

    mac_learn_table #(.NUM_ENTRIES(NE), .AGE_TICKS(AT)) dut (
        .switch_clk       (clk),
        .switch_rst       (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_dst_mac_i    (req_dst),
        .req_src_mac_i    (req_src),
        .req_port_i       (req_port),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_port_mask_o (resp_mask),
        .resp_hit_o       (resp_hit),
        .flush_i          (flush),
        .occupancy_o      (occ),
        .dbg_state_o      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of clock edges since reset released; sweeps fall on every AT-th edge.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An entry learned at edge L dies once two sweeps have happened after L.
    function automatic bit alive(int i, int t);
        if (!m_valid[i]) return 1'b0;
        if (AGING && ((t / AT) - (m_learn[i] / AT)) >= 2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int find(mac_t m, int t);
        for (int i = 0; i < NE; i++) if (alive(i, t) && m_mac[i] == m) return i;
        return -1;
    endfunction

    function automatic int model_occ(int t);
        int n = 0;
        for (int i = 0; i < NE; i++) if (alive(i, t)) n++;
        return n;
    endfunction

    function automatic port_mask_t all_but(port_t p);
        return port_mask_t'((1 << NUM_PORTS) - 1) & ~(port_mask_t'(1) << p);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        check("occ_after_flush", 64'(occ), 64'd0);
    endtask

    // Called at a negedge with the block idle.
    task automatic do_req(input mac_t dst, input mac_t src, input port_t port,
                          input int hold, input bit flush_mid);
        int a, di, idx, fi;
        port_mask_t exp_mask;
        logic exp_hit;
        bit learn;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_dst   = dst;
        req_src   = src;
        req_port  = port;
        @(posedge clk);
        @(negedge clk);
        a = edge_cnt;
        req_valid = 1'b0;
        check("resp_valid_early", 64'(resp_valid), 64'd0);
        check("req_ready_busy", 64'(req_ready), 64'd0);

        exp_hit  = 1'b0;
        exp_mask = all_but(port);
        if (!dst[40]) begin
            di = find(dst, a);
            if (di >= 0) begin
                exp_hit  = 1'b1;
                exp_mask = (m_port[di] == port) ? '0 : port_mask_t'(1) << m_port[di];
            end
        end
        learn = !src[40] && (src != '0);
        idx = 0;
        if (learn) begin
            idx = find(src, a);
            if (idx < 0) begin
                fi = -1;
                for (int i = NE - 1; i >= 0; i--) if (!alive(i, a)) fi = i;
                if (fi >= 0) idx = fi;
                else begin
                    idx   = m_ptr;
                    m_ptr = (m_ptr + 1) % NE;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_mask", 64'(resp_mask), 64'(exp_mask));
        check("resp_hit", 64'(resp_hit), 64'(exp_hit));
        if (flush_mid) flush = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_mask", 64'(resp_mask), 64'(exp_mask));
            check("hold_hit", 64'(resp_hit), 64'(exp_hit));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        flush      = 1'b0;
        check("resp_valid_done", 64'(resp_valid), 64'd0);

        if (learn) begin
            m_valid[idx] = 1'b1;
            m_mac[idx]   = src;
            m_port[idx]  = port;
            m_learn[idx] = a + 2;
        end
        if (flush_mid) model_clear();
        check("occupancy", 64'(occ), 64'(model_occ(edge_cnt)));
    endtask

    initial begin
        mac_t src, dst;
        port_t p;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_dst    = '0;
        req_src    = '0;
        req_port   = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        m_ptr      = 0;
        model_clear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_mask", 64'(resp_mask), 64'd0);
        check("rst_resp_hit", 64'(resp_hit), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // Cold lookup floods; learned unicast; filter back to ingress.
        do_req(48'h10_20_30_40_50_00, 48'h00_11_22_33_44_00, 2'd0, 0, 1'b0);
        check("cold_occ", 64'(occ), 64'd1);
        do_req(48'h00_11_22_33_44_00, 48'h00_11_22_33_44_01, 2'd2, 0, 1'b0);
        do_req(48'h00_11_22_33_44_00, 48'h00_11_22_33_44_00, 2'd0, 0, 1'b0);
        // Broadcast, then station move of ..44:00 to port 1.
        do_req(48'hFF_FF_FF_FF_FF_FF, 48'h00_11_22_33_44_03, 2'd3, 0, 1'b0);
        do_req(48'h01_00_5E_00_00_01, 48'h00_11_22_33_44_00, 2'd1, 0, 1'b0);
        do_req(48'h00_11_22_33_44_00, 48'h00_11_22_33_44_03, 2'd3, 0, 1'b0);
        // src == dst misses first, hits second time.
        do_req(48'h00_AA_BB_CC_DD_01, 48'h00_AA_BB_CC_DD_01, 2'd1, 0, 1'b0);
        do_req(48'h00_AA_BB_CC_DD_01, 48'h00_11_22_33_44_01, 2'd2, 0, 1'b0);
        // Group or zero source never learns; backpressure holds the response.
        do_req(48'h00_11_22_33_44_01, 48'h03_00_00_00_00_07, 2'd0, 0, 1'b0);
        do_req(48'h00_11_22_33_44_01, 48'h00_00_00_00_00_00, 2'd3, 5, 1'b0);

        // Fill past capacity with random sources.
        flush_idle();
        for (int i = 0; i < NE + 1; i++) begin
            src = {8'h02, 32'($urandom), 8'(i)};
            p   = port_t'($urandom_range(0, NUM_PORTS - 1));
            if (learned.size() > 0 && $urandom_range(0, 1) == 1)
                dst = learned[$urandom_range(0, learned.size() - 1)];
            else
                dst = {8'h06, 32'($urandom), 8'hFF};
            do_req(dst, src, p, $urandom_range(0, 2), 1'b0);
            learned.push_back(src);
        end
        do_req(learned[0], 48'h0, 2'd1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            dst = learned[$urandom_range(0, learned.size() - 1)];
            do_req(dst, 48'h0, port_t'($urandom_range(0, NUM_PORTS - 1)), 0, 1'b0);
        end

        // Flush during the response: result still delivered, table emptied.
        do_req(learned[5], 48'h02_00_00_00_00_99, 2'd1, 2, 1'b1);
        do_req(learned[5], 48'h0, 2'd0, 0, 1'b0);

`ifdef MAC_TABLE_AGING_EN
        flush_idle();
        do_req(48'hFF_FF_FF_FF_FF_FF, 48'h0A_00_00_00_00_01, 2'd0, 0, 1'b0);
        idle(210);
        do_req(48'h0A_00_00_00_00_01, 48'h0, 2'd1, 0, 1'b0);
        check("aged_out_occ", 64'(occ), 64'd0);
        do_req(48'hFF_FF_FF_FF_FF_FF, 48'h0A_00_00_00_00_02, 2'd2, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(60);
            do_req(48'hFF_FF_FF_FF_FF_FF, 48'h0A_00_00_00_00_02, 2'd2, 0, 1'b0);
        end
        do_req(48'h0A_00_00_00_00_02, 48'h0, 2'd1, 0, 1'b0);
        check("refreshed_hit", 64'(resp_hit), 64'd0);
`endif

        // Reset in the middle of a response drops it and empties the table.
        do_req(48'hFF_FF_FF_FF_FF_FF, 48'h00_11_22_33_44_55, 2'd2, 0, 1'b0);
        req_valid = 1'b1;
        req_dst   = 48'h00_11_22_33_44_55;
        req_src   = 48'h00_11_22_33_44_66;
        req_port  = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_resp_valid", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_occ", 64'(occ), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        model_clear();
        m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        do_req(48'h00_11_22_33_44_55, 48'h0, 2'd1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
